fpu_sched_unit: RTL

- Parametrised successor to the single-op FPU multicycle executor. It accepts FPU ops from ISSUE_WIDTH decode lanes and lets up to DEPTH ops be in flight at once, so pipelined units (add/sub, mul, cmp, cvt) take back-to-back issue.
- Non-pipelined units (div, sqrt) are guarded by busy counters.
- It schedules the single writeback slot and returns results in completion order through a valid/ready result queue.
- Sits between the issue stage and the FPU arithmetic units. It does no arithmetic; it sequences the units and collects their outputs.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_result_fifo.sv | 71 +++++++
 rtl/fpu_sched_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types and default unit timing for the FPU scheduler.
package fpu_pkg;

  localparam int FPU_NUM_UNITS = 6;
  localparam int FPU_TAG_W     = 4;
  localparam int FPU_UID_W     = 3;
  localparam int FPU_MAX_LAT   = 10;

  typedef enum logic [FPU_UID_W-1:0] {
    U_NEGABS = 3'd0,
    U_ADDSUB = 3'd1,
    U_MUL    = 3'd2,
    U_DIV    = 3'd3,
    U_SQRT   = 3'd4,
    U_CMPCVT = 3'd5
  } fpu_unit_e;

  // {V,Z,O,U,I}
  typedef logic [4:0] fpu_exc_t;

  typedef struct packed {
    logic [FPU_TAG_W-1:0] tag;
    logic [FPU_UID_W-1:0] unit;
  } sched_entry_t;

  // Cycles from unit_start to valid unit_data, indexed by unit id.
  localparam int unsigned FPU_UNIT_LAT [FPU_NUM_UNITS] = '{0, 2, 2, 8, 8, 1};
  // Bit u set: unit u takes a new op every cycle.
  localparam logic [FPU_NUM_UNITS-1:0] FPU_UNIT_PIPED = 6'b100111;

endpackage

// File: rtl/fpu_result_fifo.sv
// Circular result FIFO with occupancy count; push and pop may coincide even when full.
module fpu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 41,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full || do_pop);

  assign valid_o = (cnt_q != '0);
  assign head_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

  // Pointer and count next-state; clear wins over any push/pop.
  always_comb begin
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop  ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  // Pointer/count state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q] <= push_data_i;
  end

  // The scheduler's credit rule must keep pushes away from a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst || clr_i)
                                  !(push_i && full && !do_pop))
    else $error("fpu_result_fifo overflow");

endmodule

// File: rtl/fpu_sched_unit.sv
// FPU scheduler: picks one lane per cycle, reserves the writeback slot,
// guards div/sqrt with busy counters and queues results in completion order.
module fpu_sched_unit
  import fpu_pkg::*;
#(
  parameter int                   ISSUE_WIDTH = 2,
  parameter int                   NUM_UNITS   = FPU_NUM_UNITS,
  parameter int unsigned          UNIT_LAT [NUM_UNITS] = FPU_UNIT_LAT,
  parameter logic [NUM_UNITS-1:0] UNIT_PIPED  = FPU_UNIT_PIPED,
  parameter int                   MAX_LAT     = FPU_MAX_LAT,
  parameter int                   DEPTH       = 4,
  parameter int                   TAG_W       = FPU_TAG_W,
  localparam int                  UID_W       = $clog2(NUM_UNITS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [ISSUE_WIDTH-1:0]              req_valid,
  input  logic [ISSUE_WIDTH-1:0][UID_W-1:0]   req_unit,
  input  logic [ISSUE_WIDTH-1:0][7:0]         req_subop,
  input  logic [ISSUE_WIDTH-1:0][31:0]        req_a,
  input  logic [ISSUE_WIDTH-1:0][31:0]        req_b,
  input  logic [ISSUE_WIDTH-1:0][TAG_W-1:0]   req_tag,
  output logic [ISSUE_WIDTH-1:0]              req_ready,
  output logic [NUM_UNITS-1:0]                unit_start,
  output logic [7:0]                          unit_subop,
  output logic [31:0]                         unit_a,
  output logic [31:0]                         unit_b,
  output logic                                unit_flush,
  input  logic [NUM_UNITS-1:0][31:0]          unit_data,
  input  logic [NUM_UNITS-1:0][4:0]           unit_exc,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [TAG_W-1:0]                    res_tag,
  output logic [31:0]                         res_data,
  output logic [4:0]                          res_exc,
  output logic                                busy
);

  localparam int CNT_W = $clog2(MAX_LAT + 2);
  localparam int CR_W  = $clog2(DEPTH + 1);
  localparam int QW    = TAG_W + 32 + 5;
  localparam int NU2   = 2 ** UID_W;

  // Stage pipeline: entry k completes k cycles from now; occ_q is its valid vector.
  logic [MAX_LAT:0]                occ_q, occ_d, occ_nxt;
  sched_entry_t [MAX_LAT:0]        stg_q, stg_d;
  logic [NUM_UNITS-1:0][CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CR_W-1:0]                 infl_q, infl_d, q_count;

  logic [NUM_UNITS-1:0] start_q, start_d;
  logic [7:0]           subop_q, subop_d;
  logic [31:0]          a_q, a_d, b_q, b_d;
  logic                 flush_q;

  logic [NU2-1:0]              unit_ok;
  logic [NU2-1:0][MAX_LAT:0]   lat_mask;
  logic                        credit_ok, acc;
  logic [UID_W-1:0]            sel_unit;
  logic [7:0]                  sel_subop;
  logic [31:0]                 sel_a, sel_b;
  logic [TAG_W-1:0]            sel_tag;

  logic          push, pop, q_valid;
  logic [31:0]   push_data;
  fpu_exc_t      push_exc;
  logic [QW-1:0] q_head;

  // Where existing entries sit next cycle; a new op lands at offset L there.
  assign occ_nxt = occ_q >> 1;

  // Per-unit slot mask and eligibility; unused unit ids are never eligible.
  for (genvar u = 0; u < NU2; u++) begin : g_unit
    if (u < NUM_UNITS) begin : g_real
      assign lat_mask[u] = (MAX_LAT + 1)'(1) << UNIT_LAT[u];
      assign unit_ok[u]  = ~occ_nxt[UNIT_LAT[u]] &
                           (UNIT_PIPED[u] | (bcnt_q[u] == '0));
    end else begin : g_none
      assign lat_mask[u] = '0;
      assign unit_ok[u]  = 1'b0;
    end
  end

  // Queue count is taken before this cycle's pop, so a pop frees credit next cycle.
  assign credit_ok = ({1'b0, infl_q} + {1'b0, q_count}) < (CR_W + 1)'(DEPTH);

  // Lowest-index valid lane with an eligible op wins; nothing accepted during flush.
  always_comb begin
    req_ready = '0;
    acc       = 1'b0;
    sel_unit  = '0;
    sel_subop = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_tag   = '0;
    if (!rst && !flush && credit_ok) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (!acc && req_valid[i] && unit_ok[req_unit[i]]) begin
          acc          = 1'b1;
          req_ready[i] = 1'b1;
          sel_unit     = req_unit[i];
          sel_subop    = req_subop[i];
          sel_a        = req_a[i];
          sel_b        = req_b[i];
          sel_tag      = req_tag[i];
        end
      end
    end
  end

  // Writeback: the entry at offset 0 takes its unit's output this cycle.
  always_comb begin
    push      = occ_q[0];
    push_data = '0;
    push_exc  = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (stg_q[0].unit == UID_W'(u)) begin
        push_data = unit_data[u];
        push_exc  = unit_exc[u];
      end
    end
  end

  assign pop = q_valid && res_ready;

  // Next state for slots, stage entries, busy counters, credits and unit outputs.
  always_comb begin
    occ_d = occ_nxt | (acc ? lat_mask[sel_unit] : '0);
    stg_d = stg_q >> $bits(sched_entry_t);
    for (int k = 0; k <= MAX_LAT; k++) begin
      if (acc && lat_mask[sel_unit][k]) begin
        stg_d[k].tag  = sel_tag;
        stg_d[k].unit = sel_unit;
      end
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      bcnt_d[u] = (bcnt_q[u] != '0) ? bcnt_q[u] - 1'b1 : '0;
      if (acc && !UNIT_PIPED[u] && (sel_unit == UID_W'(u)))
        bcnt_d[u] = CNT_W'(UNIT_LAT[u] + 1);
    end
    infl_d  = infl_q + CR_W'(acc) - CR_W'(push);
    start_d = acc ? (NUM_UNITS'(1) << sel_unit) : '0;
    subop_d = acc ? sel_subop : subop_q;
    a_d     = acc ? sel_a : a_q;
    b_d     = acc ? sel_b : b_q;
    if (flush) begin
      occ_d   = '0;
      stg_d   = '0;
      bcnt_d  = '0;
      infl_d  = '0;
      start_d = '0;
      subop_d = '0;
      a_d     = '0;
      b_d     = '0;
    end
  end

  // Scheduler state and registered unit interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      stg_q   <= '0;
      bcnt_q  <= '0;
      infl_q  <= '0;
      start_q <= '0;
      subop_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flush_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      stg_q   <= stg_d;
      bcnt_q  <= bcnt_d;
      infl_q  <= infl_d;
      start_q <= start_d;
      subop_q <= subop_d;
      a_q     <= a_d;
      b_q     <= b_d;
      flush_q <= flush;
    end
  end

  fpu_result_fifo #(
    .DEPTH (DEPTH),
    .W     (QW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (flush),
    .push_i      (push),
    .push_data_i ({stg_q[0].tag, push_data, push_exc}),
    .pop_i       (pop),
    .valid_o     (q_valid),
    .head_o      (q_head),
    .count_o     (q_count)
  );

  assign res_valid                     = q_valid;
  assign {res_tag, res_data, res_exc}  = q_head;

  assign unit_start = start_q;
  assign unit_subop = subop_q;
  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign unit_flush = flush_q;
  assign busy       = (infl_q != '0) || (q_count != '0);

endmodule
